// File: rtl/midi_pkg.sv
// Shared MIDI definitions: parser states, status-byte constants and the
// status-byte length/class helpers used by the parser and the TX formatter.
package midi_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WAIT_D1 = 3'd1,
      S_WAIT_D2 = 3'd2,
      S_SYSEX   = 3'd3,
      S_RUN     = 3'd4
   } parser_state_e;

   typedef enum logic [2:0] {
      CLS_DATA   = 3'd0,
      CLS_CHAN   = 3'd1,
      CLS_SYSCOM = 3'd2,
      CLS_SYSEX  = 3'd3,
      CLS_EOX    = 3'd4,
      CLS_UNDEF  = 3'd5,
      CLS_RT     = 3'd6
   } msg_class_e;

   typedef struct packed {
      msg_class_e  cls;
      logic [1:0]  len;
   } status_info_t;

   localparam logic [3:0] ST_NOTE_OFF = 4'h8;
   localparam logic [3:0] ST_NOTE_ON  = 4'h9;
   localparam logic [7:0] ST_SYSEX    = 8'hF0;
   localparam logic [7:0] ST_EOX      = 8'hF7;
   localparam logic [7:0] ST_TUNE     = 8'hF6;
   localparam logic [7:0] RT_BASE     = 8'hF8;

   // Data-byte count that follows a status; only meaningful for channel
   // and system-common statuses.
   function automatic logic [1:0] status_len(input logic [7:0] s);
      logic [1:0] n;
      n = 2'd0;
      if (s[7:4] == 4'hC || s[7:4] == 4'hD)
         n = 2'd1;
      else if (s[7:4] != 4'hF)
         n = 2'd2;
      else begin
         case (s[3:0])
            4'h1, 4'h3: n = 2'd1;
            4'h2:       n = 2'd2;
            default:    n = 2'd0;
         endcase
      end
      return n;
   endfunction

   function automatic status_info_t status_info(input logic [7:0] b);
      status_info_t r;
      r.cls = CLS_DATA;
      r.len = 2'd0;
      if (b[7]) begin
         if (b >= RT_BASE)
            r.cls = CLS_RT;
         else if (b == ST_SYSEX)
            r.cls = CLS_SYSEX;
         else if (b == ST_EOX)
            r.cls = CLS_EOX;
         else if (b[7:4] != 4'hF)
            r.cls = CLS_CHAN;
         else if (b == ST_TUNE || b == 8'hF1 || b == 8'hF2 || b == 8'hF3)
            r.cls = CLS_SYSCOM;
         else
            r.cls = CLS_UNDEF;
         if (r.cls == CLS_CHAN || r.cls == CLS_SYSCOM)
            r.len = status_len(b);
      end
      return r;
   endfunction

endpackage

// File: rtl/midi_status_len.sv
// Combinational MIDI byte classifier: byte -> {class, data length}.
module midi_status_len
   import midi_pkg::*;
(
   input  logic [7:0]  status,
   output msg_class_e  cls,
   output logic [1:0]  len
);

   status_info_t info;

   assign info = status_info(status);
   assign cls  = info.cls;
   assign len  = info.len;

endmodule

// File: rtl/midi_msg_parser.sv
// MIDI receive byte stream -> one event word per complete message.
// Optional MIDI_NOTEOFF_NORM_EN: note-on with velocity 0 is emitted as note-off, vel 0x40.
module midi_msg_parser
   import midi_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 21477,
   parameter int TIMEOUT_W      = 16
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       byte_valid,
   input  logic [7:0] byte_data,
   output logic       byte_ready,
   output logic       ev_valid,
   input  logic       ev_ready,
   output logic [7:0] ev_status,
   output logic [6:0] ev_data1,
   output logic [6:0] ev_data2,
   output logic [1:0] ev_len,
   output logic [7:0] err_cnt
);

   parser_state_e        state, state_nx, after_msg;
   logic [7:0]           run_st, run_nx;
   logic [7:0]           cur_st, cur_nx;
   logic [6:0]           d1, d1_nx;
   logic [TIMEOUT_W-1:0] tmo_cnt;

   msg_class_e  byte_cls;
   logic [1:0]  byte_len;
   logic [7:0]  msg_st;
   logic [1:0]  msg_len;
   logic        accept, waiting, tmo_hit, emit, err_inc;
   logic [7:0]  em_st;
   logic [6:0]  em_d1, em_d2;
   logic [1:0]  em_len;

   midi_status_len u_dec (
      .status (byte_data),
      .cls    (byte_cls),
      .len    (byte_len)
   );

   assign byte_ready = !ev_valid;
   assign accept     = byte_valid && byte_ready;
   assign waiting    = (state == S_WAIT_D1) || (state == S_WAIT_D2);
   assign tmo_hit    = waiting && (tmo_cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
   // In RUN the message in progress is the running status itself.
   assign msg_st     = (state == S_RUN) ? run_st : cur_st;
   assign msg_len    = status_len(msg_st);
   // run_st is either cleared or holds a channel status.
   assign after_msg  = run_st[7] ? S_RUN : S_IDLE;

   always_comb begin
      state_nx = state;
      run_nx   = run_st;
      cur_nx   = cur_st;
      d1_nx    = d1;
      emit     = 1'b0;
      err_inc  = 1'b0;
      em_st    = msg_st;
      em_d1    = '0;
      em_d2    = '0;
      em_len   = '0;
      if (accept) begin
         case (byte_cls)
            CLS_RT: ;
            CLS_DATA: begin
               case (state)
                  S_IDLE: err_inc = 1'b1;
                  S_WAIT_D2: begin
                     emit     = 1'b1;
                     em_len   = 2'd2;
                     em_d1    = d1;
                     em_d2    = byte_data[6:0];
                     state_nx = after_msg;
                  end
                  S_WAIT_D1, S_RUN: begin
                     cur_nx = msg_st;
                     if (msg_len == 2'd2) begin
                        d1_nx    = byte_data[6:0];
                        state_nx = S_WAIT_D2;
                     end else begin
                        emit     = 1'b1;
                        em_len   = 2'd1;
                        em_d1    = byte_data[6:0];
                        state_nx = after_msg;
                     end
                  end
                  default: ;
               endcase
            end
            default: begin
               // Any non-real-time status abandons a partial message.
               if (waiting)
                  err_inc = 1'b1;
               case (byte_cls)
                  CLS_CHAN: begin
                     cur_nx   = byte_data;
                     run_nx   = byte_data;
                     state_nx = S_WAIT_D1;
                  end
                  CLS_SYSCOM: begin
                     run_nx = '0;
                     if (byte_len == 2'd0) begin
                        emit     = 1'b1;
                        em_st    = byte_data;
                        state_nx = S_IDLE;
                     end else begin
                        cur_nx   = byte_data;
                        state_nx = S_WAIT_D1;
                     end
                  end
                  CLS_SYSEX: begin
                     run_nx   = '0;
                     state_nx = S_SYSEX;
                  end
                  default: begin
                     run_nx   = '0;
                     state_nx = S_IDLE;
                  end
               endcase
            end
         endcase
      end else if (tmo_hit) begin
         err_inc  = 1'b1;
         state_nx = after_msg;
      end
`ifdef MIDI_NOTEOFF_NORM_EN
      if (em_st[7:4] == ST_NOTE_ON && em_len == 2'd2 && em_d2 == 7'd0) begin
         em_st = {ST_NOTE_OFF, em_st[3:0]};
         em_d2 = 7'h40;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         run_st    <= '0;
         cur_st    <= '0;
         d1        <= '0;
         tmo_cnt   <= '0;
         err_cnt   <= '0;
         ev_valid  <= 1'b0;
         ev_status <= '0;
         ev_data1  <= '0;
         ev_data2  <= '0;
         ev_len    <= '0;
      end else begin
         state  <= state_nx;
         run_st <= run_nx;
         cur_st <= cur_nx;
         d1     <= d1_nx;
         // A stalled downstream must never look like a stalled sender.
         if (accept || ev_valid || !waiting)
            tmo_cnt <= '0;
         else
            tmo_cnt <= tmo_cnt + 1'b1;
         if (err_inc && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
         if (emit) begin
            ev_valid  <= 1'b1;
            ev_status <= em_st;
            ev_data1  <= em_d1;
            ev_data2  <= em_d2;
            ev_len    <= em_len;
         end else if (ev_ready) begin
            ev_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/midi_msg_parser.md
Name: midi_msg_parser

Overview:
- Consumes the received MIDI byte stream (31250 baud UART receive side, after the ring buffer) and assembles complete channel/system-common messages into single-cycle-wide event words.
- Handles running status, interleaved real-time bytes, SysEx skipping and stalled partial messages.
- Feeds the piano/note front-end, which no longer has to decode raw bytes.

Parameters:
- TIMEOUT_CYCLES, 21477, clk cycles without a byte before a partial message is abandoned (about 1 ms at 21.477 MHz).
- TIMEOUT_W, 16, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock (21.477 MHz)
- reset  in  1  synchronous, active-high
- byte_valid  in  1  upstream byte available
- byte_data  in  8  upstream MIDI byte
- byte_ready  out  1  parser accepts byte this cycle
- ev_valid  out  1  event word valid
- ev_ready  in  1  downstream accepts event
- ev_status  out  8  status byte of event (running status re-inserted)
- ev_data1  out  7  first data byte (0 if none)
- ev_data2  out  7  second data byte (0 if none)
- ev_len  out  2  number of data bytes, 0..2
- err_cnt  out  8  saturating count of protocol errors/timeouts

Behaviour:
- Clock and reset: clk, rising edge. reset is synchronous and active-high.
- Reset values: ev_valid=0, ev_status/ev_data1/ev_data2/ev_len=0, err_cnt=0, state=IDLE, running status cleared, timeout counter=0.
- Byte handshake:
  - byte_ready = !ev_valid. A single output register is used; there is no skid buffer.
  - A byte is accepted when byte_valid && byte_ready.
- Event handshake:
  - An event is held stable until ev_valid && ev_ready.
  - ev_valid falls the cycle after acceptance.
- Latency: ev_valid asserts the cycle after the byte completing a message is accepted.
- Length decode by status:
  - 8n/9n/An/Bn/En: 2 data bytes.
  - Cn/Dn: 1 data byte.
  - F1/F3: 1 data byte.
  - F2: 2 data bytes.
  - F6: 0 data bytes (event emitted immediately).
  - F0: SysEx.
  - F4/F5: undefined, ignored.
  - F7: EOX.
  - F8..FF: real-time.
- States:
  - IDLE: no running status.
  - WAIT_D1, WAIT_D2: collecting data bytes.
  - SYSEX: skipping SysEx.
  - RUN: running status held, waiting for the next data byte.
- Transitions:
  - Channel status (80..EF) from any state → WAIT_D1. Running status is set.
  - Data byte in RUN → treated as D1 of the running status.
  - 2-byte message: D1 → WAIT_D2; D2 → emit event, then RUN.
  - 1-byte message: D1 → emit event, then RUN.
  - System common (F1,F2,F3,F6) → clears running status. Its events end in IDLE, not RUN.
  - F0 → SYSEX and clears running status. All data bytes are dropped silently. F7 or any non-real-time status exits SYSEX; the status is then processed normally.
  - F4/F5 and stray F7 → IDLE, running status cleared, no error.
- Real-time bytes (F8..FF): dropped with no state, counter or running-status change, including inside WAIT_D1/WAIT_D2/SYSEX.
- Error cases (each increments err_cnt, saturating at 255):
  - Data byte in IDLE: discarded.
  - Non-real-time status arriving in WAIT_D1/WAIT_D2: partial message discarded, new status processed.
- Timeout:
  - The counter clears on every accepted byte and counts only in WAIT_D1/WAIT_D2.
  - When it reaches TIMEOUT_CYCLES-1: partial message discarded, err_cnt++, state → RUN if running status is a channel status, else IDLE.
  - The counter also clears while ev_valid is high, so downstream stall is never a timeout.
- Output fields:
  - Unused data fields are 0.
  - ev_len is exact.
  - Data bytes are stored as byte_data[6:0].
- Reset asserted mid-message or mid-event drops everything, returning to the reset values above.

Optional Feature:
- Macro: MIDI_NOTEOFF_NORM_EN.
- Defined: a note-on (9n) with data2==0 is emitted as ev_status=8n, data2=0x40. Running status stays 9n.
- Undefined: the event is emitted verbatim as 9n with data2=0.

Decomposition:
- Package midi_pkg:
  - parser state enum.
  - Status constants: ST_NOTE_OFF, ST_NOTE_ON, ST_SYSEX, ST_EOX, ST_TUNE, RT_BASE.
  - Function returning data length/class from a status byte.
- Sub-module midi_status_len: combinational status → {class, len} decoder, shared later by a MIDI transmit formatter.

Test Plan:
- 90 3C 64 → one event 90/3C/64 len 2. The following 3E 00 → event 90/3E/00 via running status; with MIDI_NOTEOFF_NORM_EN, 80/3E/40.
- C2 05 F8 06 (F8 between the data bytes) → events C2/05 len 1 and C2/06 len 1. F8 is invisible; err_cnt=0.
- F0 7E 7F 09 01 F7 then 3C → no events. 3C counted as error: err_cnt=1, state IDLE.
- 90 3C, then idle for TIMEOUT_CYCLES → no event, err_cnt=1, state RUN. Then 40 50 → event 90/40/50.
- ev_ready held low with byte_valid high during 90 3C 64 45 7F → byte_ready=0 after the first event. First event held; release gives 90/3C/64 then 90/45/7F, no loss.
- 90 3C followed by B0 07 7F → err_cnt=1, event B0/07/7F only. Reset mid-message → all outputs 0 next cycle.
